gcd_master: RTL and testbench

Initiator side of the Go/Done GCD handshake. Accepts operand pairs from an upstream valid/ready source, launches the GCD engine with a one-cycle `gcd_go` pulse, waits for `gcd_done` under a timeout, and returns the result downstream over valid/ready. Operand pairs containing zero are resolved locally without starting the engine, because a subtract-loop engine never terminates on them. The block sits between the system datapath and a `WIDTH`-bit GCD engine.

---
 rtl/gcd_master_if.sv | 54 +++++
 rtl/gcd_master.sv | 128 ++++++++++++
 tb/tb_gcd_master.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_master_if.sv
// gcd_master_if: upstream, downstream and engine signals of gcd_master.
// master is the gcd_master side; slave is the system and engine side.
interface gcd_master_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic [7:0]       op_count;
    logic [WIDTH-1:0] gcd_x;
    logic [WIDTH-1:0] gcd_y;
    logic             gcd_go;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;

    modport master (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  out_ready,
        input  gcd_done,
        input  gcd_result,
        output in_ready,
        output out_valid,
        output out_gcd,
        output out_err,
        output op_count,
        output gcd_x,
        output gcd_y,
        output gcd_go
    );

    modport slave (
        output in_valid,
        output in_x,
        output in_y,
        output out_ready,
        output gcd_done,
        output gcd_result,
        input  in_ready,
        input  out_valid,
        input  out_gcd,
        input  out_err,
        input  op_count,
        input  gcd_x,
        input  gcd_y,
        input  gcd_go
    );
endinterface

// File: rtl/gcd_master.sv
// gcd_master: initiator side of the Go/Done GCD handshake.
// Zero operand pairs bypass the engine; engine runs are timeout-guarded.
module gcd_master #(
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    gcd_master_if.master bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    tmo_q, tmo_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
    logic             out_err_q, out_err_d;
    logic [7:0]       op_count_q, op_count_d;
    logic [WIDTH-1:0] gcd_x_q, gcd_x_d;
    logic [WIDTH-1:0] gcd_y_q, gcd_y_d;
    logic             gcd_go_q, gcd_go_d;
    logic             has_zero;

    assign has_zero = (bus.in_x == '0) || (bus.in_y == '0);

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        out_valid_d = out_valid_q;
        out_gcd_d   = out_gcd_q;
        out_err_d   = out_err_q;
        op_count_d  = op_count_q;
        gcd_x_d     = gcd_x_q;
        gcd_y_d     = gcd_y_q;
        gcd_go_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (has_zero) begin
                        // OR of the pair is the nonzero operand, or 0.
                        out_gcd_d   = bus.in_x | bus.in_y;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        gcd_x_d  = bus.in_x;
                        gcd_y_d  = bus.in_y;
                        gcd_go_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tmo_q != T_LAST) begin
                    tmo_d = tmo_q + CW'(1);
                end
                if (bus.gcd_done) begin
                    out_gcd_d   = bus.gcd_result;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (tmo_q == T_LAST) begin
                    out_gcd_d   = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (!out_err_q) begin
                        op_count_d = op_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_gcd_q   <= '0;
            out_err_q   <= 1'b0;
            op_count_q  <= 8'd0;
            gcd_x_q     <= '0;
            gcd_y_q     <= '0;
            gcd_go_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_gcd_q   <= out_gcd_d;
            out_err_q   <= out_err_d;
            op_count_q  <= op_count_d;
            gcd_x_q     <= gcd_x_d;
            gcd_y_q     <= gcd_y_d;
            gcd_go_q    <= gcd_go_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_gcd   = out_gcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.op_count  = op_count_q;
    assign bus.gcd_x     = gcd_x_q;
    assign bus.gcd_y     = gcd_y_q;
    assign bus.gcd_go    = gcd_go_q;
endmodule

// File: tb/tb_gcd_master.sv
// tb_gcd_master: randomized scenarios against a Euclid reference model
// and a behavioural engine that answers a chosen number of cycles after go.
module tb_gcd_master;
    localparam int W  = 5;
    localparam int TO = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_count   = 0;

    gcd_master_if #(.WIDTH(W)) bus ();

    gcd_master #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    always #5 clock = ~clock;

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Drives one accept and plays the engine. dly<=0: engine never answers.
    // stray: a done pulse while the block is in ISSUE. lat counts edges
    // from the accept edge (inclusive) to the edge after which out_valid is seen.
    task automatic run_op(input int x, input int y, input int dly,
                          input bit stray, output int gv, output bit ev,
                          output int lat, output int gos,
                          output int gx, output int gy);
        int go_cyc;
        go_cyc = 0;
        gos = 0; lat = -1; gx = -1; gy = -1; gv = -1; ev = 1'b0;
        bus.in_x = W'(x);
        bus.in_y = W'(y);
        bus.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (bus.out_valid === 1'b1) begin
                lat = e;
                gv  = int'(bus.out_gcd);
                ev  = bus.out_err;
                break;
            end
            if (bus.gcd_go === 1'b1) begin
                gos++;
                go_cyc = e;
                gx = int'(bus.gcd_x);
                gy = int'(bus.gcd_y);
            end
            bus.gcd_done = 1'b0;
            bus.gcd_result = '0;
            if (go_cyc != 0 && stray && e == go_cyc) begin
                bus.gcd_done = 1'b1;
                bus.gcd_result = W'($urandom);
            end
            if (go_cyc != 0 && dly > 0 && e == go_cyc + dly) begin
                bus.gcd_done = 1'b1;
                bus.gcd_result = W'(ref_gcd(x, y));
            end
            @(posedge clock);
            @(negedge clock);
        end
        bus.gcd_done = 1'b0;
    endtask

    task automatic drain(input bit err);
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
        if (!err) exp_count = (exp_count + 1) % 256;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.gcd_go} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 1000",
                     {bus.in_ready, bus.out_valid, bus.out_err, bus.gcd_go});
        end
        vectors++;
        if (bus.out_gcd !== '0 || bus.gcd_x !== '0 || bus.gcd_y !== '0) begin
            miscompares++;
            $display("FAIL reset_data got gcd=%0d x=%0d y=%0d want 0",
                     bus.out_gcd, bus.gcd_x, bus.gcd_y);
        end
        vectors++;
        if (bus.op_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d want 0", bus.op_count);
        end
        reset_n = 1'b1;
        exp_count = 0;
        @(negedge clock);
    endtask

    task automatic test_engine();
        int g, lat, gos, gx, gy, x, y, d;
        bit e, s;
        run_op(12, 18, 4, 1'b0, g, e, lat, gos, gx, gy);
        vectors++;
        if (gos != 1 || gx != 12 || gy != 18) begin
            miscompares++;
            $display("FAIL engine_go got pulses=%0d x=%0d y=%0d want 1 12 18",
                     gos, gx, gy);
        end
        vectors++;
        if (g != 6 || e != 1'b0 || lat != 6) begin
            miscompares++;
            $display("FAIL engine_result got gcd=%0d err=%0d lat=%0d want 6 0 6",
                     g, e, lat);
        end
        drain(e);
        vectors++;
        if (bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL engine_count got %0d want %0d", bus.op_count, exp_count);
        end
        repeat (12) begin
            x = $urandom_range(1, 31);
            y = $urandom_range(1, 31);
            d = $urandom_range(1, 6);
            s = 1'($urandom_range(0, 1));
            run_op(x, y, d, s, g, e, lat, gos, gx, gy);
            vectors++;
            if (g != ref_gcd(x, y) || e || gos != 1 || lat != d + 2) begin
                miscompares++;
                $display("FAIL engine_rand (%0d,%0d) got gcd=%0d err=%0d go=%0d lat=%0d want %0d 0 1 %0d",
                         x, y, g, e, gos, lat, ref_gcd(x, y), d + 2);
            end
            drain(e);
            vectors++;
            if (bus.op_count !== 8'(exp_count)) begin
                miscompares++;
                $display("FAIL engine_rand_count got %0d want %0d",
                         bus.op_count, exp_count);
            end
        end
    endtask

    task automatic test_bypass();
        int xs[$], ys[$];
        int g, lat, gos, gx, gy, v;
        bit e;
        xs = '{0, 9, 0};
        ys = '{7, 0, 0};
        repeat (6) begin
            v = $urandom_range(1, 31);
            if ($urandom_range(0, 1) == 0) begin
                xs.push_back(0); ys.push_back(v);
            end else begin
                xs.push_back(v); ys.push_back(0);
            end
        end
        foreach (xs[i]) begin
            run_op(xs[i], ys[i], 3, 1'b0, g, e, lat, gos, gx, gy);
            vectors++;
            if (g != ref_gcd(xs[i], ys[i]) || e || gos != 0 || lat != 1) begin
                miscompares++;
                $display("FAIL bypass (%0d,%0d) got gcd=%0d err=%0d go=%0d lat=%0d want %0d 0 0 1",
                         xs[i], ys[i], g, e, gos, lat, ref_gcd(xs[i], ys[i]));
            end
            drain(e);
            vectors++;
            if (bus.op_count !== 8'(exp_count)) begin
                miscompares++;
                $display("FAIL bypass_count got %0d want %0d", bus.op_count, exp_count);
            end
        end
    endtask

    task automatic test_timeout();
        int g, lat, gos, gx, gy;
        bit e;
        run_op(7, 5, 0, 1'b0, g, e, lat, gos, gx, gy);
        vectors++;
        if (g != 0 || e != 1'b1 || gos != 1 || lat != TO + 2) begin
            miscompares++;
            $display("FAIL timeout got gcd=%0d err=%0d go=%0d lat=%0d want 0 1 1 %0d",
                     g, e, gos, lat, TO + 2);
        end
        drain(e);
        vectors++;
        if (bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL timeout_count got %0d want %0d", bus.op_count, exp_count);
        end
    endtask

    task automatic test_done_vs_timeout();
        int g, lat, gos, gx, gy;
        bit e;
        run_op(15, 10, TO, 1'b0, g, e, lat, gos, gx, gy);
        vectors++;
        if (g != 5 || e != 1'b0 || lat != TO + 2) begin
            miscompares++;
            $display("FAIL done_on_timeout got gcd=%0d err=%0d lat=%0d want 5 0 %0d",
                     g, e, lat, TO + 2);
        end
        drain(e);
        run_op(15, 10, TO + 1, 1'b0, g, e, lat, gos, gx, gy);
        vectors++;
        if (g != 0 || e != 1'b1 || lat != TO + 2) begin
            miscompares++;
            $display("FAIL done_too_late got gcd=%0d err=%0d lat=%0d want 0 1 %0d",
                     g, e, lat, TO + 2);
        end
        drain(e);
        vectors++;
        if (bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL dvt_count got %0d want %0d", bus.op_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int g, lat, gos, gx, gy;
        bit e;
        run_op(20, 12, 2, 1'b0, g, e, lat, gos, gx, gy);
        bus.in_x = W'(3);
        bus.in_y = W'(0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.gcd_done = 1'(c % 2 == 0);
            bus.gcd_result = W'($urandom);
            @(posedge clock);
            @(negedge clock);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_gcd !== W'(ref_gcd(20, 12)) ||
                bus.out_err !== 1'b0 || bus.in_ready !== 1'b0 ||
                bus.gcd_go !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure c=%0d got v=%0d gcd=%0d err=%0d rdy=%0d go=%0d want 1 %0d 0 0 0",
                         c, bus.out_valid, bus.out_gcd, bus.out_err,
                         bus.in_ready, bus.gcd_go, ref_gcd(20, 12));
            end
        end
        bus.in_valid = 1'b0;
        bus.gcd_done = 1'b0;
        drain(1'b0);
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL backpressure_release got v=%0d rdy=%0d cnt=%0d want 0 1 %0d",
                     bus.out_valid, bus.in_ready, bus.op_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int y;
        bit exp_v;
        y = $urandom_range(1, 31);
        bus.in_x = '0;
        bus.in_y = W'(y);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            @(negedge clock);
            exp_v = (i % 2 == 0);
            vectors++;
            if (bus.out_valid !== exp_v || bus.in_ready !== !exp_v ||
                (exp_v && bus.out_gcd !== W'(y))) begin
                miscompares++;
                $display("FAIL back_to_back i=%0d got v=%0d rdy=%0d gcd=%0d want %0d %0d %0d",
                         i, bus.out_valid, bus.in_ready, bus.out_gcd,
                         exp_v, !exp_v, y);
            end
            if (!exp_v) begin
                y = $urandom_range(1, 31);
                bus.in_y = W'(y);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 4) % 256;
        vectors++;
        if (bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL back_to_back_count got %0d want %0d", bus.op_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        int g, lat, gos, gx, gy;
        bit e;
        bus.in_x = W'(3);
        bus.in_y = W'(5);
        bus.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.gcd_go} !== 4'b1000 ||
            bus.gcd_x !== '0 || bus.gcd_y !== '0 || bus.out_gcd !== '0 ||
            bus.op_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid got rdy=%0d v=%0d err=%0d go=%0d x=%0d y=%0d gcd=%0d cnt=%0d want all reset",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.gcd_go,
                     bus.gcd_x, bus.gcd_y, bus.out_gcd, bus.op_count);
        end
        exp_count = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(21, 14, 3, 1'b0, g, e, lat, gos, gx, gy);
        vectors++;
        if (g != 7 || e != 1'b0 || gos != 1) begin
            miscompares++;
            $display("FAIL after_reset got gcd=%0d err=%0d go=%0d want 7 0 1", g, e, gos);
        end
        drain(e);
        vectors++;
        if (bus.op_count !== 8'(exp_count)) begin
            miscompares++;
            $display("FAIL after_reset_count got %0d want %0d", bus.op_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        int g, lat, gos, gx, gy, x, y, d;
        bit e;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_count = 0;
        @(negedge clock);
        for (int n = 0; n < 256; n++) begin
            x = $urandom_range(1, 31);
            y = $urandom_range(1, 31);
            d = $urandom_range(1, 3);
            case ($urandom_range(0, 2))
                0: x = 0;
                1: y = 0;
                default: ;
            endcase
            run_op(x, y, d, 1'b0, g, e, lat, gos, gx, gy);
            vectors++;
            if (g != ref_gcd(x, y) || e) begin
                miscompares++;
                $display("FAIL wrap_op n=%0d (%0d,%0d) got gcd=%0d err=%0d want %0d 0",
                         n, x, y, g, e, ref_gcd(x, y));
            end
            drain(e);
            if (n == 254) begin
                vectors++;
                if (bus.op_count !== 8'd255) begin
                    miscompares++;
                    $display("FAIL wrap_255 got %0d want 255", bus.op_count);
                end
            end
        end
        vectors++;
        if (bus.op_count !== 8'd0 || exp_count != 0) begin
            miscompares++;
            $display("FAIL wrap got %0d want 0 (model %0d)", bus.op_count, exp_count);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.out_ready  = 1'b0;
        bus.gcd_done   = 1'b0;
        bus.gcd_result = '0;
        test_reset();
        test_engine();
        test_bypass();
        test_timeout();
        test_done_vs_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
